// File: rtl/pump_actuator_if.sv
// Level-controller / pump-actuator signal bundle.
// The controller side drives the run requests, the error flags and the fault acknowledge;
// the actuator side drives the motor enables and the status flags.
interface pump_actuator_if;
  logic [1:0] C;
  logic [1:0] Pout;
  logic       Ack;
  logic [1:0] M;
  logic       Alarm;
  logic       Busy;

  modport master (output C, Pout, Ack, input M, Alarm, Busy);
  modport slave  (input C, Pout, Ack, output M, Alarm, Busy);
endinterface

// File: rtl/pump_actuator.sv
// Two-channel pump actuator: minimum on/off times, fault latch and optional start stagger.
// Define STAGGER_EN to space successive pump starts by START_DLY cycles (channel 0 wins ties).
module pump_actuator #(
  parameter int unsigned START_DLY = 4,
  parameter int unsigned MIN_ON    = 8,
  parameter int unsigned MIN_OFF   = 8,
  parameter int unsigned CNT_W     = 8
) (
  input logic             clk,
  input logic             reset,
  pump_actuator_if.slave  bus
);

  localparam int unsigned CntMax = (1 << CNT_W) - 1;

  // Reject timer settings the counters cannot represent.
  if (START_DLY < 1 || START_DLY > CntMax) begin : g_bad_start_dly
    $error("START_DLY out of range");
  end
  if (MIN_ON < 1 || MIN_ON > CntMax) begin : g_bad_min_on
    $error("MIN_ON out of range");
  end
  if (MIN_OFF < 1 || MIN_OFF > CntMax) begin : g_bad_min_off
    $error("MIN_OFF out of range");
  end

  typedef enum logic [1:0] {StIdle, StRun, StCool, StFault} state_e;

  state_e             state_q [2];
  state_e             state_d [2];
  logic [CNT_W-1:0]   on_q    [2];
  logic [CNT_W-1:0]   on_d    [2];
  logic [CNT_W-1:0]   off_q   [2];
  logic [CNT_W-1:0]   off_d   [2];
  logic [1:0]         start;
  logic               fault;

  assign fault = |bus.Pout;

`ifdef STAGGER_EN
  logic [CNT_W-1:0] stg_q;
  logic [CNT_W-1:0] stg_d;

  always_comb begin
    start    = '0;
    start[0] = (state_q[0] == StIdle) && bus.C[0] && !fault && (stg_q == '0);
    start[1] = (state_q[1] == StIdle) && bus.C[1] && !fault && (stg_q == '0) && !start[0];
    stg_d    = (stg_q != '0) ? stg_q - 1'b1 : '0;
    if (|start) begin
      stg_d = CNT_W'(START_DLY - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end
`else
  always_comb begin
    start = '0;
    for (int i = 0; i < 2; i++) begin
      start[i] = (state_q[i] == StIdle) && bus.C[i] && !fault;
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      on_d[i]    = on_q[i];
      off_d[i]   = off_q[i];
      unique case (state_q[i])
        StIdle: begin
          if (start[i]) begin
            state_d[i] = StRun;
            on_d[i]    = CNT_W'(MIN_ON - 1);
          end
        end
        StRun: begin
          // Requests dropping before the minimum on-time expires are ignored.
          if (on_q[i] != '0) begin
            on_d[i] = on_q[i] - 1'b1;
          end else if (!bus.C[i]) begin
            state_d[i] = StCool;
            off_d[i]   = CNT_W'(MIN_OFF - 1);
          end
        end
        StCool: begin
          if (off_q[i] != '0) begin
            off_d[i] = off_q[i] - 1'b1;
          end else begin
            state_d[i] = StIdle;
          end
        end
        StFault: begin
          if (bus.Ack) begin
            state_d[i] = StCool;
            off_d[i]   = CNT_W'(MIN_OFF - 1);
          end
        end
        default: state_d[i] = StIdle;
      endcase
      // Emergency stop overrides every other transition, including Ack.
      if (fault) begin
        state_d[i] = StFault;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        state_q[i] <= StIdle;
        on_q[i]    <= '0;
        off_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        on_q[i]    <= on_d[i];
        off_q[i]   <= off_d[i];
      end
    end
  end

  always_comb begin
    bus.M     = '0;
    bus.Alarm = 1'b0;
    bus.Busy  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.M[i]  = (state_q[i] == StRun);
      bus.Alarm = bus.Alarm | (state_q[i] == StFault);
      bus.Busy  = bus.Busy | (state_q[i] == StRun) | (state_q[i] == StCool);
    end
  end

endmodule

// File: tb/tb_pump_actuator.sv
// Scoreboard bench for pump_actuator: each step drives one cycle of inputs and queues the
// hand-computed outputs for that cycle; a negedge monitor pops and compares them.
module tb_pump_actuator;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pump_actuator_if bus ();

  pump_actuator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [1:0]  m;
    logic        alarm;
    logic        busy;
    logic [7:0]  phase;
    logic [15:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;
  int   cyc    = 0;

  // Outputs expected during this cycle come from the previous cycle's inputs.
  task automatic step(input logic r, input logic [1:0] c, input logic [1:0] p, input logic a,
                      input logic [1:0] em, input logic ea, input logic eb);
    @(posedge clk);
    #1;
    sb.push_back({em, ea, eb, 8'(phase), 16'(cyc)});
    reset    = r;
    bus.C    = c;
    bus.Pout = p;
    bus.Ack  = a;
    cyc++;
  endtask

  task automatic steps(input int n, input logic r, input logic [1:0] c, input logic [1:0] p,
                       input logic a, input logic [1:0] em, input logic ea, input logic eb);
    for (int k = 0; k < n; k++) step(r, c, p, a, em, ea, eb);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({bus.M, bus.Alarm, bus.Busy} !== {e.m, e.alarm, e.busy}) begin
          errors++;
          $display("FAIL outputs phase%0d cycle%0d: got M=%b Alarm=%b Busy=%b, want M=%b Alarm=%b Busy=%b",
                   e.phase, e.cyc, bus.M, bus.Alarm, bus.Busy, e.m, e.alarm, e.busy);
        end
      end
    end
  end

  initial begin
    reset    = 1'b1;
    bus.C    = 2'b00;
    bus.Pout = 2'b00;
    bus.Ack  = 1'b0;

    // Phase 0: reset state.
    phase = 0; cyc = 0;
    steps(2, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    // Phase 1: single run, request dropped early, full min on and off times.
    phase = 1; cyc = 0;
    step (   0, 2'b01, 2'b00, 0, 2'b00, 0, 0);   // cycle 0
    steps(2, 0, 2'b01, 2'b00, 0, 2'b01, 0, 1);   // 1-2
    steps(6, 0, 2'b00, 2'b00, 0, 2'b01, 0, 1);   // 3-8
    steps(8, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1);   // 9-16
    steps(2, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0);   // 17-18

    // Phase 2: dual request, then reset (with Pout/Ack asserted) while M=11, then C=10.
    phase = 2; cyc = 0;
    step (   0, 2'b11, 2'b00, 0, 2'b00, 0, 0);   // 0
`ifdef STAGGER_EN
    steps(4, 0, 2'b11, 2'b00, 0, 2'b01, 0, 1);   // 1-4
`else
    steps(4, 0, 2'b11, 2'b00, 0, 2'b11, 0, 1);   // 1-4
`endif
    step (   0, 2'b11, 2'b00, 0, 2'b11, 0, 1);   // 5
    step (   1, 2'b11, 2'b10, 1, 2'b11, 0, 1);   // 6: reset wins
    step (   0, 2'b10, 2'b00, 0, 2'b00, 0, 0);   // 7
    steps(2, 0, 2'b10, 2'b00, 0, 2'b10, 0, 1);   // 8-9
    steps(6, 0, 2'b00, 2'b00, 0, 2'b10, 0, 1);   // 10-15
    steps(8, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1);   // 16-23
    step (   0, 2'b00, 2'b00, 0, 2'b00, 0, 0);   // 24

    // Phase 3: emergency stop mid-run, ignored Ack, accepted Ack, cool-down.
    phase = 3; cyc = 0;
    step (   0, 2'b01, 2'b00, 0, 2'b00, 0, 0);   // 0
    step (   0, 2'b01, 2'b00, 0, 2'b01, 0, 1);   // 1
    step (   0, 2'b01, 2'b10, 0, 2'b01, 0, 1);   // 2: Pout raised
    steps(2, 0, 2'b00, 2'b10, 1, 2'b00, 1, 0);   // 3-4: Ack with Pout!=0
    step (   0, 2'b00, 2'b00, 1, 2'b00, 1, 0);   // 5: Ack accepted
    steps(8, 0, 2'b00, 2'b00, 0, 2'b00, 0, 1);   // 6-13
    step (   0, 2'b00, 2'b00, 0, 2'b00, 0, 0);   // 14

    // Phase 4: request reasserted during COOL is held off until IDLE, then reset mid-run.
    phase = 4; cyc = 0;
    step (   0, 2'b01, 2'b00, 0, 2'b00, 0, 0);   // 0
    step (   0, 2'b00, 2'b00, 0, 2'b01, 0, 1);   // 1
    steps(7, 0, 2'b00, 2'b00, 0, 2'b01, 0, 1);   // 2-8
    steps(8, 0, 2'b01, 2'b00, 0, 2'b00, 0, 1);   // 9-16
    step (   0, 2'b01, 2'b00, 0, 2'b00, 0, 0);   // 17
    steps(2, 0, 2'b01, 2'b00, 0, 2'b01, 0, 1);   // 18-19
    step (   1, 2'b01, 2'b00, 0, 2'b01, 0, 1);   // 20
    step (   0, 2'b00, 2'b00, 0, 2'b00, 0, 0);   // 21

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pump_actuator.md
PUMP_ACTUATOR -- requirements
Module: pump_actuator

Interface
REQ-001 Parameter START_DLY, default 4: minimum cycles between successive pump starts, legal range 1..2^CNT_W-1.
REQ-002 Parameter MIN_ON, default 8: minimum cycles a pump stays on once started, legal range 1..2^CNT_W-1.
REQ-003 Parameter MIN_OFF, default 8: minimum cycles a pump stays off after stopping, legal range 1..2^CNT_W-1.
REQ-004 Parameter CNT_W, default 8: width of every internal timer.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 C  input  2  pump run requests from the level controller; bit i requests pump i.
REQ-008 Pout  input  2  error flags from the level controller; any nonzero value is an emergency stop.
REQ-009 Ack  input  1  operator fault acknowledge, level-sampled.
REQ-010 M  output  2  motor enables; bit i drives pump i.
REQ-011 Alarm  output  1  high while any channel is in FAULT.
REQ-012 Busy  output  1  high while any channel is in RUN or COOL.

Function
REQ-013 Each channel i SHALL run its own state machine with states IDLE, RUN, COOL and FAULT.
REQ-014 Outputs SHALL be Moore-decoded from registered state: M[i]=1 only in RUN, Alarm=OR(FAULT), Busy=OR(RUN,COOL); any input change becomes visible on outputs no earlier than the next edge.
REQ-015 Pout!=00 sampled in any state SHALL move both channels to FAULT at that edge; this has priority over every other transition, including an unexpired minimum on-time.
REQ-016 IDLE->RUN SHALL occur when C[i]=1, Pout=00 and the shared stagger timer is 0; on that edge the channel's on-timer loads MIN_ON-1 and the stagger timer loads START_DLY-1.
REQ-017 If both channels qualify for IDLE->RUN in the same cycle, channel 0 SHALL start and channel 1 SHALL remain in IDLE.
REQ-018 The stagger timer SHALL decrement by 1 each cycle while nonzero and saturate at 0; only the IDLE->RUN transition reloads it.
REQ-019 In RUN, the on-timer SHALL decrement each cycle while nonzero; RUN->COOL SHALL occur when the on-timer is 0 and C[i]=0, loading the off-timer with MIN_OFF-1.
REQ-020 C[i] deasserting while the on-timer is nonzero SHALL be ignored; the pump stays on for exactly MIN_ON cycles minimum.
REQ-021 In COOL, the off-timer SHALL decrement each cycle; COOL->IDLE SHALL occur when it is 0; C[i]=1 during COOL SHALL be ignored.
REQ-022 FAULT->COOL SHALL occur only when Ack=1 and Pout=00 in the same cycle, loading the off-timer with MIN_OFF-1; Ack with Pout!=00 SHALL be ignored.
REQ-023 Timers SHALL never wrap below 0.

Reset
REQ-024 reset=1 at an edge SHALL force both channels to IDLE, clear all timers including stagger, and give M=00, Alarm=0, Busy=0 from the next cycle, regardless of the current state or any run in progress.
REQ-025 reset SHALL override Pout, C and Ack in the same cycle.

Configuration
REQ-026 With STAGGER_EN defined, REQ-016 to REQ-018 apply as written.
REQ-027 Without STAGGER_EN, the stagger timer and the REQ-017 arbitration are removed, and both channels may enter RUN on the same edge.

Verification (defaults; cycle 0 = first cycle after reset released)
REQ-028 C=01 at cycle 0, C=00 at cycle 3 -> M=01 during cycles 1-8, M=00 from cycle 9, Busy=1 through cycle 16, Busy=0 from cycle 17.
REQ-029 STAGGER_EN defined, C=11 from cycle 0 -> M=01 from cycle 1, M=11 from cycle 5.
REQ-030 Pump 0 in RUN, Pout=10 at cycle k -> M=00 and Alarm=1 from cycle k+1; Ack=1 with Pout=10 -> no change; Ack=1 with Pout=00 at cycle j -> Alarm=0 from j+1, channel returns to IDLE after 8 COOL cycles.
REQ-031 C=01 pulse, then C=01 reasserted on the first COOL cycle -> M stays 00 for all 8 COOL cycles, then M=01 one cycle after IDLE is reached.
REQ-032 reset=1 while M=11 -> M=00, Alarm=0, Busy=0 the following cycle; a new C=10 after release -> M=10 one cycle later, with no stagger wait.
REQ-033 STAGGER_EN undefined, C=11 at cycle 0 -> M=11 from cycle 1.
